aes_cbc: RTL

AES_CBC -- requirements
Module: aes_cbc

---
 rtl/aes_cbc_if.sv | 52 +++++
 rtl/aes_cbc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_if.sv
// Signal bundle for aes_cbc: key/IV load, block streams, AES core command/response and status.
// slave = the chaining controller, master = the host and core around it.
interface aes_cbc_if #(parameter int NK = 4);
  localparam int KW = 32 * NK;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [127:0]  data;
    logic [1:0]    func;
    logic          enable;
  } aes_in_type;

  typedef struct packed {
    logic         ready;
    logic [127:0] result;
  } aes_out_type;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [KW-1:0] cfg_key;
  logic [127:0]  cfg_iv;
  logic          cfg_dec;
  logic          cfg_ecb;

  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          in_last;

  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          out_last;

  aes_in_type    aes_in;
  aes_out_type   aes_out;

  logic          busy;
  logic          err;

  modport slave (
    input  cfg_valid, cfg_key, cfg_iv, cfg_dec, cfg_ecb,
    input  in_valid, in_data, in_last, out_ready, aes_out,
    output cfg_ready, in_ready, out_valid, out_data, out_last, aes_in, busy, err
  );

  modport master (
    output cfg_valid, cfg_key, cfg_iv, cfg_dec, cfg_ecb,
    output in_valid, in_data, in_last, out_ready, aes_out,
    input  cfg_ready, in_ready, out_valid, out_data, out_last, aes_in, busy, err
  );
endinterface

// File: rtl/aes_cbc.sv
// CBC chaining controller around an external AES core, with a core-response timeout.
// Define AES_CBC_ECB_EN to honour cfg_ecb (chain XOR forced to zero); otherwise always CBC.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no key loaded, waiting for a key/IV load
// KEY    | key expansion command issued, waiting for the core
// READY  | key loaded, accepting an input block or a new key/IV
// CRYPT  | block command issued, waiting for the core result
// OUT    | result presented on the output stream until accepted
// ERR    | core timed out; only a key/IV load (or rst) recovers
module aes_cbc #(
  parameter int WAIT_LIMIT = 255,
  parameter int NK         = 4
) (
  input  logic      clk,
  input  logic      rst,
  aes_cbc_if.slave  bus
);

  localparam int KW = 32 * NK;
  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_READY,
    S_CRYPT,
    S_OUT,
    S_ERR
  } state_t;

  state_t        state_q, state_d;

  logic [KW-1:0] key_q;
  logic [127:0]  iv_q;
  logic [127:0]  chain_q;
  logic [127:0]  blk_q;
  logic          last_q;
  logic          dec_q;
  logic [127:0]  out_data_q;
  logic          out_last_q;
  logic          err_q;
  logic [CW-1:0] wait_cnt;

  logic          cfg_fire;
  logic          in_fire;
  logic          out_fire;
  logic          waiting;
  logic          timeout;
  logic          first_cycle;
  logic [127:0]  chain_eff;

  assign cfg_fire    = bus.cfg_valid & bus.cfg_ready;
  assign in_fire     = bus.in_valid & bus.in_ready;
  assign out_fire    = bus.out_valid & bus.out_ready;
  assign waiting     = ((state_q == S_KEY) || (state_q == S_CRYPT)) && !bus.aes_out.ready;
  assign timeout     = waiting && (wait_cnt == WAIT_LAST);
  assign first_cycle = (wait_cnt == '0);

`ifdef AES_CBC_ECB_EN
  logic ecb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ecb_q <= 1'b0;
    end else if (cfg_fire) begin
      ecb_q <= bus.cfg_ecb;
    end
  end

  assign chain_eff = ecb_q ? '0 : chain_q;
`else
  logic unused_ecb;
  assign unused_ecb = bus.cfg_ecb;
  assign chain_eff  = chain_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.cfg_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.aes_in    = '0;

    case (state_q)
      S_IDLE: begin
        bus.cfg_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cfg_valid) state_d = S_KEY;
      end

      S_KEY: begin
        bus.aes_in.func   = 2'd1;
        bus.aes_in.key    = key_q;
        bus.aes_in.enable = first_cycle;
        if (bus.aes_out.ready) state_d = S_READY;
        else if (timeout)      state_d = S_ERR;
      end

      S_READY: begin
        bus.cfg_ready = 1'b1;
        bus.busy      = 1'b0;
        // A pending key/IV load wins, so a block is never half-accepted.
        bus.in_ready  = !bus.cfg_valid;
        if (bus.cfg_valid)     state_d = S_KEY;
        else if (bus.in_valid) state_d = S_CRYPT;
      end

      S_CRYPT: begin
        bus.aes_in.func   = dec_q ? 2'd3 : 2'd2;
        bus.aes_in.key    = key_q;
        bus.aes_in.data   = dec_q ? blk_q : (blk_q ^ chain_eff);
        bus.aes_in.enable = first_cycle;
        if (bus.aes_out.ready) state_d = S_OUT;
        else if (timeout)      state_d = S_ERR;
      end

      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_READY;
      end

      S_ERR: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) state_d = S_KEY;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      iv_q       <= '0;
      chain_q    <= '0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      dec_q      <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (cfg_fire) begin
        key_q   <= bus.cfg_key;
        iv_q    <= bus.cfg_iv;
        chain_q <= bus.cfg_iv;
        dec_q   <= bus.cfg_dec;
        err_q   <= 1'b0;
      end

      if (in_fire) begin
        blk_q  <= bus.in_data;
        last_q <= bus.in_last;
      end

      if (cfg_fire || in_fire) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (timeout) err_q <= 1'b1;

      // Encrypt chains on the ciphertext just produced, decrypt on the ciphertext just consumed.
      if ((state_q == S_CRYPT) && bus.aes_out.ready) begin
        out_data_q <= dec_q ? (bus.aes_out.result ^ chain_eff) : bus.aes_out.result;
        out_last_q <= last_q;
        chain_q    <= dec_q ? blk_q : bus.aes_out.result;
      end

      if (out_fire && out_last_q) chain_q <= iv_q;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.err      = err_q;

endmodule
